pc_reg_ctrl: RTL and testbench
==============================

Name: pc_reg_ctrl

Overview:
- Architectural PC register and processor-status controller for the SEQ Y86-64 core.
- Sits directly downstream of the PC-update logic: consumes next-PC each clock and presents the current PC to fetch.
- Owns the run/halt/error state machine that freezes the PC when execution ends.
- Provides optional saturating cycle and retired-instruction counters.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE and begins execution.
- stall  input  1  hold the PC this cycle; no retire.
- newPC  input  64  next PC from the PC-update stage.
- icode  input  4  icode of the instruction at the current PC.
- instr_valid  input  1  fetch decoded a legal icode/ifun.
- imem_error  input  1  fetch address out of range.
- dmem_error  input  1  memory stage address out of range.
- PC  output  64  current architectural PC.
- stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
- running  output  1  high only in RUN state.
- cycle_cnt  output  CNT_W  cycles spent in RUN; only with PERF_CNT_EN.
- retire_cnt  output  CNT_W  instructions retired; only with PERF_CNT_EN.

Behaviour:
- Reset (rst=1 at posedge) has priority over every other input, including in mid-run and terminal states:
  - PC=RESET_PC, stat=AOK, state=IDLE, running=0, counters=0.
- States: IDLE, RUN, HALTED, FAULT.
- IDLE:
  - PC holds, stat=AOK.
  - start=1 moves to RUN next cycle; PC is unchanged, so the first fetch is at RESET_PC.
  - All other inputs are ignored.
- RUN: each posedge, evaluate in this priority order:
  1. stall=1: PC holds; no retire; status checks are skipped this cycle.
  2. imem_error=1: FAULT, stat<=ADR, PC holds.
  3. instr_valid=0: FAULT, stat<=INS, PC holds.
  4. dmem_error=1: FAULT, stat<=ADR, PC holds.
  5. icode==IHALT (4'h0): HALTED, stat<=HLT, PC holds at the halt address; the halt counts as retired.
  6. Otherwise: PC<=newPC, one instruction retires, stat stays AOK.
- start while in RUN has no effect.
- HALTED / FAULT:
  - Terminal: PC, stat and counters frozen.
  - Only rst leaves these states; start is ignored.
- running is registered and equals (state==RUN).
- Outputs change only on posedge; no combinational path from inputs to outputs.
- newPC is loaded verbatim with no alignment or range check; faults are reported by fetch on the next cycle via imem_error.
- Simultaneous imem_error and dmem_error: stat=ADR, because imem_error wins.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every posedge in RUN, stalled cycles included.
  - retire_cnt increments on every retiring edge: normal PC advance and the halt.
  - Both saturate at all-ones (no wrap) and clear on rst.
- Undefined:
  - Counter ports are still present and tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - stat constants: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - State enum: IDLE, RUN, HALTED, FAULT.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated twice under PERF_CNT_EN.

Test Plan:
- Reset, then IDLE behaviour: rst 2 cycles; newPC=64'h40, start=0 for 5 cycles -> PC=0, stat=1, running=0 throughout.
- Normal advance: start pulse, then newPC sequence 0x0A, 0x14, 0x1E with icode=INOP, valid=1 -> PC follows one cycle later; retire_cnt=3, cycle_cnt=3.
- Halt: icode=IHALT at PC=0x1E -> stat=2 next cycle, PC stays 0x1E, running=0; further start and newPC changes are ignored; retire_cnt=4.
- Stall and faults:
  - stall=1 for 2 cycles with newPC=0x99 -> PC unchanged, cycle_cnt +2, retire_cnt +0.
  - Then imem_error=1 together with instr_valid=0 -> stat=3 (ADR), PC frozen.
- Invalid instruction: instr_valid=0 alone in RUN -> stat=4, FAULT.
- Reset mid-run: rst asserted during RUN with PC=0x50 -> next cycle PC=RESET_PC, IDLE, stat=1, counters 0.
- Counter saturation (CNT_W=4): run 20 cycles -> cycle_cnt=4'hF.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/status constants and the PC controller state type
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, sync active-high clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pc_reg_ctrl.sv
// pc_reg_ctrl: SEQ Y86-64 PC register with run/halt/fault status FSM.
// Define PERF_CNT_EN to build the saturating cycle/retire counters.
module pc_reg_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic [63:0]      newPC,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);
  state_t      state, state_n;
  logic [63:0] pc_n;
  logic [2:0]  stat_n;
  always_comb begin
    state_n = state;
    pc_n    = PC;
    stat_n  = stat;
    if (state == IDLE && start)
      state_n = RUN;
    else if (state == RUN && !stall) begin
      if (imem_error) begin
        state_n = FAULT;
        stat_n  = SADR;
      end else if (!instr_valid) begin
        state_n = FAULT;
        stat_n  = SINS;
      end else if (dmem_error) begin
        state_n = FAULT;
        stat_n  = SADR;
      end else if (icode == IHALT) begin
        state_n = HALTED;
        stat_n  = SHLT;
      end else
        pc_n = newPC;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      PC      <= RESET_PC;
      stat    <= SAOK;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      PC      <= pc_n;
      stat    <= stat_n;
      running <= state_n == RUN;
    end
  end
`ifdef PERF_CNT_EN
  // A halt retires too, so only the fault and stall paths are excluded.
  logic retire;
  assign retire = state == RUN && !stall && !imem_error && instr_valid && !dmem_error;
  sat_counter #(.W(CNT_W)) u_cycle (.clk(clk), .rst(rst), .inc(state == RUN), .cnt(cycle_cnt));
  sat_counter #(.W(CNT_W)) u_retire (.clk(clk), .rst(rst), .inc(retire), .cnt(retire_cnt));
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_reg_ctrl.sv
// tb_pc_reg_ctrl: directed self-checking bench for pc_reg_ctrl (CNT_W=4)
module tb_pc_reg_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0;
  logic [63:0] newPC = 64'h0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0;
  logic [63:0] PC;
  logic [2:0]  stat;
  logic        running;
  logic [3:0]  cycle_cnt, retire_cnt;
  int          n_cmp = 0, n_bad = 0;

  pc_reg_ctrl #(.RESET_PC(64'h0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .newPC(newPC),
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .PC(PC), .stat(stat), .running(running),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt(input int v);
`ifdef PERF_CNT_EN
    return 64'(v);
`else
    return 64'(0 * v);
`endif
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic status(input string tag, input logic [63:0] pc, input logic [2:0] st, input logic run);
    check({tag, "_pc"}, PC, pc);
    check({tag, "_stat"}, 64'(stat), 64'(st));
    check({tag, "_run"}, 64'(running), 64'(run));
  endtask

  task automatic counters(input string tag, input int cyc, input int ret);
    check({tag, "_cyc"}, 64'(cycle_cnt), cnt(cyc));
    check({tag, "_ret"}, 64'(retire_cnt), cnt(ret));
  endtask

  task automatic restart;
    rst = 1'b1; stall = 1'b0; icode = 4'h1; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_error = 1'b0;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step(2);
    status("reset", 64'h0, 3'd1, 1'b0);
    counters("reset", 0, 0);
    rst = 1'b0; newPC = 64'h40;
    for (int i = 0; i < 5; i++) begin
      step();
      status("idle", 64'h0, 3'd1, 1'b0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    status("start", 64'h0, 3'd1, 1'b1);
    counters("start", 0, 0);
    newPC = 64'h0A; step(); check("adv1", PC, 64'h0A);
    newPC = 64'h14; step(); check("adv2", PC, 64'h14);
    newPC = 64'h1E; step();
    status("adv3", 64'h1E, 3'd1, 1'b1);
    counters("adv3", 3, 3);
    stall = 1'b1; newPC = 64'h99;
    step(2);
    status("stall", 64'h1E, 3'd1, 1'b1);
    counters("stall", 5, 3);
    stall = 1'b0; icode = 4'h0;
    step();
    status("halt", 64'h1E, 3'd2, 1'b0);
    counters("halt", 6, 4);
    start = 1'b1; newPC = 64'h77; icode = 4'h1;
    step(2);
    start = 1'b0;
    status("halt_frz", 64'h1E, 3'd2, 1'b0);
    counters("halt_frz", 6, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    status("rst_term", 64'h0, 3'd1, 1'b0);
    counters("rst_term", 0, 0);
    restart();
    newPC = 64'h50; step();
    check("mid_pc", PC, 64'h50);
    rst = 1'b1; step(); rst = 1'b0;
    status("rst_mid", 64'h0, 3'd1, 1'b0);
    counters("rst_mid", 0, 0);
    restart();
    newPC = 64'h50; step();
    imem_error = 1'b1; instr_valid = 1'b0;
    step();
    status("imem", 64'h50, 3'd3, 1'b0);
    imem_error = 1'b0; instr_valid = 1'b1; newPC = 64'h60;
    step();
    status("imem_frz", 64'h50, 3'd3, 1'b0);
    restart();
    instr_valid = 1'b0; newPC = 64'h30;
    step();
    status("ins", 64'h0, 3'd4, 1'b0);
    restart();
    dmem_error = 1'b1; newPC = 64'h30;
    step();
    status("dmem", 64'h0, 3'd3, 1'b0);
    restart();
    stall = 1'b1; instr_valid = 1'b0; imem_error = 1'b1;
    step(20);
    status("sat", 64'h0, 3'd1, 1'b1);
    counters("sat", 15, 0);
    stall = 1'b0; imem_error = 1'b0; instr_valid = 1'b1; newPC = 64'h8;
    step(16);
    counters("sat_ret", 15, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
